// File: rtl/i2c_slave.sv
// I2C target answering one 7-bit address; oversampled SCL/SDA, byte strobes.
// Define I2C_SLAVE_STRETCH_EN to hold SCL low until txValid at each load point.
module i2c_slave #(
  parameter logic [6:0]  OWN_ADDRESS = 7'h42,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire        scl,
  inout  wire        sda,
  input  logic       ackEnable,
  input  logic [7:0] txData,
  input  logic       txValid,
  output logic [7:0] rxData,
  output logic       rxStrobe,
  output logic       txReq,
  output logic       addressed,
  output logic       readNWrite,
  output logic       stopStrobe
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX_BYTE,
    RX_ACK, TX_BYTE, TX_ACK, IGNORE
  } state_t;

  localparam logic [3:0] HOLD = 4'(HOLD_CYCLES);

  state_t     state;
  logic [3:0] bitcnt;
  logic [7:0] shreg;
  logic [3:0] hold;
  logic       sda_oe, scl_oe, sda_pend;
  logic       acked, stretch;
  logic       scl_s1, scl_s2, scl_h;
  logic       sda_s1, sda_s2, sda_h;
  logic       scl_rise, scl_fall;
  logic       start_det, stop_det, load_pt;

  assign sda = sda_oe ? 1'b0 : 1'bz;
  assign scl = scl_oe ? 1'b0 : 1'bz;

`ifndef I2C_SLAVE_STRETCH_EN
  logic unused_txvalid;
  assign unused_txvalid = txValid;
`endif

  // Two-flop synchronizers plus a history flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_h <= 1'b1;
      sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_h <= 1'b1;
    end else begin
      scl_s1 <= scl; scl_s2 <= scl_s1; scl_h <= scl_s2;
      sda_s1 <= sda; sda_s2 <= sda_s1; sda_h <= sda_s2;
    end
  end

  assign scl_rise  = scl_s2 & ~scl_h;
  assign scl_fall  = ~scl_s2 & scl_h;
  assign start_det = sda_h & ~sda_s2 & scl_s2;
  assign stop_det  = ~sda_h & sda_s2 & scl_s2;
  assign load_pt   = scl_fall & ~start_det & ~stop_det &
                     (((state == ADDR_ACK) & readNWrite) |
                      (state == TX_ACK));

  // Protocol FSM, delayed SDA drive updates and clock stretching.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bitcnt     <= '0;
      shreg      <= '0;
      hold       <= '0;
      sda_oe     <= 1'b0;
      scl_oe     <= 1'b0;
      sda_pend   <= 1'b0;
      acked      <= 1'b0;
      stretch    <= 1'b0;
      rxData     <= '0;
      rxStrobe   <= 1'b0;
      txReq      <= 1'b0;
      addressed  <= 1'b0;
      readNWrite <= 1'b0;
      stopStrobe <= 1'b0;
    end else begin
      rxStrobe   <= 1'b0;
      txReq      <= 1'b0;
      stopStrobe <= 1'b0;
      if (hold != 4'd0) begin
        hold <= hold - 4'd1;
        if (hold == 4'd1) begin
          sda_oe <= sda_pend;
          if (!stretch) scl_oe <= 1'b0;
        end
      end
      if (stop_det) begin
        state      <= IDLE;
        stopStrobe <= addressed;
        addressed  <= 1'b0;
        sda_oe     <= 1'b0;
        scl_oe     <= 1'b0;
        hold       <= '0;
        stretch    <= 1'b0;
      end else if (start_det) begin
        state     <= ADDR;
        bitcnt    <= '0;
        addressed <= 1'b0;
        sda_oe    <= 1'b0;
        scl_oe    <= 1'b0;
        hold      <= '0;
        stretch   <= 1'b0;
      end else begin
        unique case (state)
          IDLE, IGNORE: ;
          ADDR: begin
            if (scl_rise && bitcnt != 4'd8) begin
              shreg  <= {shreg[6:0], sda_s2};
              bitcnt <= bitcnt + 4'd1;
            end else if (scl_fall && bitcnt == 4'd8) begin
              if (shreg[7:1] == OWN_ADDRESS) begin
                state      <= ADDR_ACK;
                sda_pend   <= 1'b1;
                hold       <= HOLD;
                addressed  <= 1'b1;
                readNWrite <= shreg[0];
                txReq      <= shreg[0];
              end else begin
                state <= IGNORE;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              bitcnt <= '0;
              if (readNWrite) begin
                state <= TX_BYTE;
              end else begin
                state    <= RX_BYTE;
                sda_pend <= 1'b0;
                hold     <= HOLD;
              end
            end
          end
          RX_BYTE: begin
            if (scl_rise && bitcnt != 4'd8) begin
              shreg  <= {shreg[6:0], sda_s2};
              bitcnt <= bitcnt + 4'd1;
              if (bitcnt == 4'd7) begin
                rxData   <= {shreg[6:0], sda_s2};
                rxStrobe <= 1'b1;
              end
            end else if (scl_fall && bitcnt == 4'd8) begin
              state    <= RX_ACK;
              acked    <= ackEnable;
              sda_pend <= ackEnable;
              hold     <= HOLD;
            end
          end
          RX_ACK: begin
            if (scl_fall) begin
              bitcnt   <= '0;
              sda_pend <= 1'b0;
              hold     <= HOLD;
              state    <= acked ? RX_BYTE : IGNORE;
            end
          end
          TX_BYTE: begin
`ifdef I2C_SLAVE_STRETCH_EN
            if (stretch) begin
              if (txValid) begin
                stretch  <= 1'b0;
                shreg    <= txData;
                sda_pend <= ~txData[7];
                hold     <= HOLD;
              end
            end else
`endif
            if (scl_fall) begin
              hold <= HOLD;
              if (bitcnt == 4'd7) begin
                sda_pend <= 1'b0;
                state    <= TX_ACK;
              end else begin
                shreg    <= {shreg[6:0], 1'b0};
                sda_pend <= ~shreg[6];
                bitcnt   <= bitcnt + 4'd1;
              end
            end
          end
          TX_ACK: begin
            if (scl_rise) begin
              if (!sda_s2) begin
                txReq <= 1'b1;
              end else begin
                state     <= IGNORE;
                addressed <= 1'b0;
              end
            end else if (scl_fall) begin
              state  <= TX_BYTE;
              bitcnt <= '0;
            end
          end
        endcase
        if (load_pt) begin
`ifdef I2C_SLAVE_STRETCH_EN
          if (!txValid) begin
            stretch  <= 1'b1;
            scl_oe   <= 1'b1;
            sda_pend <= 1'b0;
            hold     <= HOLD;
          end else
`endif
          begin
            shreg    <= txData;
            sda_pend <= ~txData[7];
            hold     <= HOLD;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: bit-banged bus master on pulled-up lines.
// Expected values are hand-computed per transfer.
module tb_i2c_slave;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       ackEnable = 1'b1;
  logic       txValid = 1'b1;
  logic [7:0] txData = 8'h00;
  logic [7:0] rxData;
  logic       rxStrobe, txReq, addressed, readNWrite, stopStrobe;
  wire        scl, sda;

  assign scl = m_scl ? 1'bz : 1'b0;
  assign sda = m_sda ? 1'bz : 1'b0;
  pullup (scl);
  pullup (sda);

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0, tx_cnt = 0, stop_cnt = 0, slv_low = 0;
  int low_run = 0, max_low = 0;
  logic [7:0] rx_last = 8'h00;

  always #5 clk = ~clk;

  i2c_slave dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda),
    .ackEnable(ackEnable), .txData(txData), .txValid(txValid),
    .rxData(rxData), .rxStrobe(rxStrobe), .txReq(txReq),
    .addressed(addressed), .readNWrite(readNWrite),
    .stopStrobe(stopStrobe)
  );

  // Bus/strobe monitor sampled on the inactive edge.
  always @(negedge clk) begin
    if (rxStrobe) begin
      rx_last = rxData;
      rx_cnt++;
    end
    if (txReq) tx_cnt++;
    if (stopStrobe) stop_cnt++;
    if (m_sda && sda === 1'b0) slv_low++;
    if (scl === 1'b0) begin
      low_run++;
      if (low_run > max_low) max_low = low_run;
    end else begin
      low_run = 0;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not end, got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic bitx(input logic b, output logic r);
    int n;
    repeat (Q) @(posedge clk);
    m_sda = b;
    repeat (Q) @(posedge clk);
    m_scl = 1'b1;
    @(posedge clk);
    n = 0;
    while (scl !== 1'b1 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 5000) chk("scl_release_timeout", n, 0);
    repeat (Q) @(posedge clk);
    r = sda;
    repeat (Q) @(posedge clk);
    m_scl = 1'b0;
  endtask

  task automatic start_c();
    m_sda = 1'b0;
    repeat (Q) @(posedge clk);
    m_scl = 1'b0;
  endtask

  task automatic rstart_c();
    repeat (Q) @(posedge clk);
    m_sda = 1'b1;
    repeat (Q) @(posedge clk);
    m_scl = 1'b1;
    repeat (Q) @(posedge clk);
    m_sda = 1'b0;
    repeat (Q) @(posedge clk);
    m_scl = 1'b0;
  endtask

  task automatic stop_c();
    repeat (Q) @(posedge clk);
    m_sda = 1'b0;
    repeat (Q) @(posedge clk);
    m_scl = 1'b1;
    repeat (Q) @(posedge clk);
    m_sda = 1'b1;
    repeat (2 * Q) @(posedge clk);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bitx(d[i], r);
    bitx(1'b1, ack);
  endtask

  task automatic rd_bits(output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bitx(1'b1, r);
      d[i] = r;
    end
  endtask

  initial begin
    logic       a;
    logic [7:0] d;
    int         s0, s1, s2;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_rxData", rxData, 8'h00);
    chk("rst_rxStrobe", rxStrobe, 0);
    chk("rst_txReq", txReq, 0);
    chk("rst_addressed", addressed, 0);
    chk("rst_readNWrite", readNWrite, 0);
    chk("rst_stopStrobe", stopStrobe, 0);
    chk("rst_sda", sda, 1);
    chk("rst_scl", scl, 1);
    rst = 1'b0;
    repeat (4 * Q) @(posedge clk);

    // write 0x42+W, A5, 3C, STOP
    s0 = rx_cnt; s1 = stop_cnt;
    start_c();
    wr_byte(8'h84, a);
    chk("w_addr_ack", a, 0);
    chk("w_addressed", addressed, 1);
    chk("w_readNWrite", readNWrite, 0);
    wr_byte(8'hA5, a);
    chk("w_d0_ack", a, 0);
    chk("w_d0_rx", rx_last, 8'hA5);
    wr_byte(8'h3C, a);
    chk("w_d1_ack", a, 0);
    chk("w_d1_rx", rx_last, 8'h3C);
    stop_c();
    chk("w_rx_cnt", rx_cnt - s0, 2);
    chk("w_stop_cnt", stop_cnt - s1, 1);
    chk("w_addressed_after_stop", addressed, 0);

    // wrong address 0x43+W
    s0 = rx_cnt; s1 = stop_cnt; s2 = slv_low;
    start_c();
    wr_byte(8'h86, a);
    chk("na_addr_nack", a, 1);
    chk("na_addressed", addressed, 0);
    wr_byte(8'h55, a);
    chk("na_data_nack", a, 1);
    stop_c();
    chk("na_sda_driven", slv_low - s2, 0);
    chk("na_rx_cnt", rx_cnt - s0, 0);
    chk("na_stop_cnt", stop_cnt - s1, 0);

    // read 0x42+R: 0x96 (ACK), 0x5A (NACK)
    s0 = tx_cnt; s1 = stop_cnt;
    txData = 8'h96;
    start_c();
    wr_byte(8'h85, a);
    chk("r_addr_ack", a, 0);
    chk("r_readNWrite", readNWrite, 1);
    chk("r_txreq_first", tx_cnt - s0, 1);
    rd_bits(d);
    chk("r_byte0", d, 8'h96);
    txData = 8'h5A;
    bitx(1'b0, a);
    chk("r_txreq_second", tx_cnt - s0, 2);
    rd_bits(d);
    chk("r_byte1", d, 8'h5A);
    bitx(1'b1, a);
    s2 = slv_low;
    repeat (2 * Q) @(posedge clk);
    chk("r_sda_released", slv_low - s2, 0);
    chk("r_addressed_after_nack", addressed, 0);
    chk("r_txreq_total", tx_cnt - s0, 2);
    stop_c();
    chk("r_stop_cnt", stop_cnt - s1, 0);

    // write 0x10, repeated START, read one byte
    s0 = rx_cnt; s1 = stop_cnt;
    txData = 8'hC3;
    start_c();
    wr_byte(8'h84, a);
    chk("sr_w_addr_ack", a, 0);
    wr_byte(8'h10, a);
    chk("sr_w_data_ack", a, 0);
    chk("sr_rx", rx_last, 8'h10);
    rstart_c();
    chk("sr_addressed_cleared", addressed, 0);
    wr_byte(8'h85, a);
    chk("sr_r_addr_ack", a, 0);
    chk("sr_no_stopstrobe", stop_cnt - s1, 0);
    chk("sr_readNWrite", readNWrite, 1);
    rd_bits(d);
    chk("sr_r_byte", d, 8'hC3);
    bitx(1'b1, a);
    stop_c();
    chk("sr_rx_cnt", rx_cnt - s0, 1);

    // ackEnable low: data byte NACKed, later bytes ignored
    s0 = rx_cnt;
    start_c();
    wr_byte(8'h84, a);
    chk("ne_addr_ack", a, 0);
    ackEnable = 1'b0;
    wr_byte(8'h77, a);
    chk("ne_d0_nack", a, 1);
    chk("ne_d0_rx", rx_last, 8'h77);
    ackEnable = 1'b1;
    wr_byte(8'h11, a);
    chk("ne_d1_nack", a, 1);
    chk("ne_rx_cnt", rx_cnt - s0, 1);
    stop_c();

`ifdef I2C_SLAVE_STRETCH_EN
    // stretched read: txValid arrives 200 cycles after load point
    txData  = 8'hB4;
    txValid = 1'b0;
    start_c();
    wr_byte(8'h85, a);
    chk("st_addr_ack", a, 0);
    max_low = 0;
    fork
      begin
        repeat (200) @(posedge clk);
        txValid = 1'b1;
      end
    join_none
    rd_bits(d);
    chk("st_byte", d, 8'hB4);
    chk("st_held_200", (max_low >= 200) ? 1 : 0, 1);
    bitx(1'b1, a);
    stop_c();
`endif

    // reset while target is driving a 0 data bit
    txData = 8'h00;
    start_c();
    wr_byte(8'h85, a);
    chk("rs_addr_ack", a, 0);
    repeat (Q) @(posedge clk);
    chk("rs_sda_driven", sda, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rs_sda_released", sda, 1);
    chk("rs_scl_released", m_scl ? scl : 1'b1, 1);
    chk("rs_addressed", addressed, 0);
    chk("rs_readNWrite", readNWrite, 0);
    @(negedge clk);
    rst = 1'b0;
    m_scl = 1'b1;
    repeat (4 * Q) @(posedge clk);
    chk("rs_idle_sda", sda, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
